// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: loads a parallel pattern and shifts it out MSB-first with optional repeats/gaps.
// Optional even-parity bit per repetition when SEQ_PARITY_EN is defined.
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [REP_W-1:0]   load_rep,
  input  logic               abort,
  output logic               c_out,
  output logic               c_valid,
  output logic               busy,
  output logic               done
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

`ifdef SEQ_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

  state_t             state_q, state_n;
  logic [MAX_LEN-1:0] shift_q, shift_n;
  logic [MAX_LEN-1:0] hold_shift_q;
  logic [LEN_W-1:0]   hold_len_q;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_n;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_n;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_n;
  logic               c_out_n, c_valid_n, done_n;
  logic               accept, rep_end, reload;
`ifdef SEQ_PARITY_EN
  logic               par_q, par_n;
`endif

  assign load_ready = (state_q == IDLE);
  assign accept     = load_ready && load_valid;

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt_q;
    rep_cnt_n = rep_cnt_q;
    gap_cnt_n = gap_cnt_q;
    c_out_n   = 1'b0;
    c_valid_n = 1'b0;
    done_n    = 1'b0;
    rep_end   = 1'b0;
    reload    = 1'b0;
`ifdef SEQ_PARITY_EN
    par_n     = par_q;
`endif
    if (abort && state_q != IDLE) begin
      state_n = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_n   = SEND;
            // Left-align so bit [load_len] lands on the MSB.
            shift_n   = load_pattern << (LEN_MAX - load_len);
            bit_cnt_n = load_len;
            rep_cnt_n = load_rep;
`ifdef SEQ_PARITY_EN
            par_n     = 1'b0;
`endif
          end
        end
        SEND: begin
          shift_n = shift_q << 1;
`ifdef SEQ_PARITY_EN
          par_n   = par_q ^ shift_q[MAX_LEN-1];
`endif
          if (bit_cnt_q == '0) begin
`ifdef SEQ_PARITY_EN
            state_n   = PAR;
            c_valid_n = 1'b1;
            c_out_n   = par_n;
`else
            rep_end   = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) reload = 1'b1;
          else gap_cnt_n = gap_cnt_q - 1'b1;
        end
`ifdef SEQ_PARITY_EN
        PAR: rep_end = 1'b1;
`endif
        default: state_n = IDLE;
      endcase

      if (rep_end) begin
        if (rep_cnt_q == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (GAP_CYC > 0) begin
          state_n   = GAP;
          gap_cnt_n = GAP_LAST;
        end else begin
          reload = 1'b1;
        end
      end

      if (reload) begin
        state_n   = SEND;
        shift_n   = hold_shift_q;
        bit_cnt_n = hold_len_q;
        rep_cnt_n = rep_cnt_q - 1'b1;
`ifdef SEQ_PARITY_EN
        par_n     = 1'b0;
`endif
      end

      // Output registers show the bit that the next state presents.
      if (state_n == SEND) begin
        c_valid_n = 1'b1;
        c_out_n   = shift_n[MAX_LEN-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_shift_q <= '0;
      hold_len_q   <= '0;
      bit_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      c_out        <= 1'b0;
      c_valid      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef SEQ_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      rep_cnt_q <= rep_cnt_n;
      gap_cnt_q <= gap_cnt_n;
      c_out     <= c_out_n;
      c_valid   <= c_valid_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
`ifdef SEQ_PARITY_EN
      par_q     <= par_n;
`endif
      if (accept) begin
        hold_shift_q <= shift_n;
        hold_len_q   <= load_len;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (gap 2 and gap 0) driven in parallel against a timeline model.
module tb_seq_pattern_gen;

`ifdef SEQ_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic v;
    logic d;
    logic dn;
    logic bsy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_pattern;
  logic [3:0]  load_len;
  logic [3:0]  load_rep;
  logic        abort;
  logic [1:0]  load_ready, c_out, c_valid, busy, done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sched [2][0:1023];
  int   rd [2];
  int   wr [2];
  exp_t cur [2];

  always #5 clk = ~clk;

  seq_pattern_gen #(.MAX_LEN(16), .LEN_W(4), .REP_W(4), .GAP_CYC(2)) u_dut_gap (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[0]),
    .load_pattern(load_pattern), .load_len(load_len), .load_rep(load_rep), .abort(abort),
    .c_out(c_out[0]), .c_valid(c_valid[0]), .busy(busy[0]), .done(done[0]));

  seq_pattern_gen #(.MAX_LEN(16), .LEN_W(4), .REP_W(4), .GAP_CYC(0)) u_dut_b2b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[1]),
    .load_pattern(load_pattern), .load_len(load_len), .load_rep(load_rep), .abort(abort),
    .c_out(c_out[1]), .c_valid(c_valid[1]), .busy(busy[1]), .done(done[1]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic exp_t mk(input logic v, input logic d, input logic dn, input logic bsy);
    exp_t e;
    e.v = v; e.d = d; e.dn = dn; e.bsy = bsy;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    sched[i][wr[i]] = e;
    wr[i]++;
  endtask

  // Whole-transfer timeline: one entry per output cycle after the accept edge.
  task automatic build(input int i, input logic [15:0] pat, input int len, input int rep);
    logic p;
    rd[i] = 0;
    wr[i] = 0;
    for (int r = 0; r <= rep; r++) begin
      p = 1'b0;
      for (int b = len; b >= 0; b--) begin
        push(i, mk(1'b1, pat[b], 1'b0, 1'b1));
        p = p ^ pat[b];
      end
      if (PB == 1) push(i, mk(1'b1, p, 1'b0, 1'b1));
      if (r < rep) for (int g = 0; g < gap_of(i); g++) push(i, mk(1'b0, 1'b0, 1'b0, 1'b1));
    end
    push(i, mk(1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic model_edge(input int i);
    logic idle;
    idle = (rd[i] == wr[i]);
    if (abort && !idle) begin
      rd[i]  = wr[i];
      cur[i] = '0;
    end else begin
      if (load_valid && idle) build(i, load_pattern, int'(load_len), int'(load_rep));
      if (rd[i] != wr[i]) begin
        cur[i] = sched[i][rd[i]];
        rd[i]++;
      end else begin
        cur[i] = '0;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rd[i]  = 0;
      wr[i]  = 0;
      cur[i] = '0;
    end
  endtask

  task automatic check_outs(input int i);
    check($sformatf("ready%0d", i), 32'(load_ready[i]), 32'(rd[i] == wr[i]));
    check($sformatf("c_valid%0d", i), 32'(c_valid[i]), 32'(cur[i].v));
    check($sformatf("c_out%0d", i), 32'(c_out[i]), 32'(cur[i].d));
    check($sformatf("done%0d", i), 32'(done[i]), 32'(cur[i].dn));
    check($sformatf("busy%0d", i), 32'(busy[i]), 32'(cur[i].bsy));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outs(i);
  endtask

  task automatic drain();
    int n;
    n = 0;
    load_valid = 1'b0;
    abort = 1'b0;
    while ((rd[0] != wr[0] || rd[1] != wr[1]) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(n < 1000), 32'd1);
  endtask

  task automatic set_load(input logic [15:0] pat, input int len, input int rep);
    load_pattern = pat;
    load_len     = 4'(len);
    load_rep     = 4'(rep);
    load_valid   = 1'b1;
  endtask

  task automatic run_xfer(input int i, input logic [15:0] pat, input int len, input int rep);
    int cyc, vc;
    cyc = 0;
    vc  = 0;
    set_load(pat, len, rep);
    do begin
      tick();
      load_valid = 1'b0;
      cyc++;
      vc += int'(c_valid[i]);
    end while (!done[i] && cyc < 400);
    check($sformatf("lat%0d_l%0d_r%0d", i, len, rep), 32'(cyc),
          32'((len + 1 + PB) * (rep + 1) + rep * gap_of(i) + 1));
    check($sformatf("vcnt%0d_l%0d_r%0d", i, len, rep), 32'(vc), 32'((len + 1 + PB) * (rep + 1)));
    drain();
  endtask

  initial begin
    logic [3:0] bits;
    logic [4:0] bits5;
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_pattern = '0;
    load_len = '0;
    load_rep = '0;
    abort = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outs(i);
    rst_n = 1'b1;

    // Single load, MSB-first.
    set_load(16'h000B, 3, 0);
    tick();
    load_valid = 1'b0;
    bits[3] = c_out[0];
    for (int k = 2; k >= 0; k--) begin
      tick();
      bits[k] = c_out[0];
    end
    check("s1_bits", 32'(bits), 32'h0000_000B);
    for (int k = 0; k < 1 + PB; k++) tick();
    check("s1_done", 32'(done[0]), 32'd1);
    check("s1_ready", 32'(load_ready[0]), 32'd1);
    drain();

    // Repeats with and without gap, plus length/repeat boundaries.
    run_xfer(0, 16'h0002, 1, 2);
    run_xfer(1, 16'h0001, 0, 3);
    run_xfer(0, 16'($urandom), 15, 15);
    run_xfer(1, 16'($urandom), 0, 15);
    run_xfer(0, 16'h0001, 0, 0);
    run_xfer(1, 16'h0007, 2, 1);

    // Abort after 5 bits, then immediate reload.
    set_load(16'hA5A5, 15, 0);
    tick();
    load_valid = 1'b0;
    bits5[4] = c_out[0];
    for (int k = 3; k >= 0; k--) begin
      tick();
      bits5[k] = c_out[0];
    end
    check("s4_bits", 32'(bits5), 32'h0000_0014);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s4_valid", 32'(c_valid[0]), 32'd0);
    check("s4_done", 32'(done[0]), 32'd0);
    check("s4_ready", 32'(load_ready[0]), 32'd1);
    set_load(16'h000B, 3, 0);
    tick();
    load_valid = 1'b0;
    check("s4_reload", 32'({c_valid[0], c_out[0]}), 32'd3);
    drain();

    // Asynchronous reset while the gap instance is in its gap.
    set_load(16'h0002, 1, 2);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 2 + PB; k++) tick();
    check("s5_ingap", 32'({c_valid[0], busy[0]}), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("s5_rst_outs", 32'({c_valid, c_out, busy, done}), 32'd0);
    check("s5_rst_ready", 32'(load_ready), 32'd3);
    model_reset();
    rst_n = 1'b1;
    set_load(16'h000B, 3, 0);
    tick();
    load_valid = 1'b0;
    bits[3] = c_out[0];
    for (int k = 2; k >= 0; k--) begin
      tick();
      bits[k] = c_out[0];
    end
    check("s5_bits", 32'(bits), 32'h0000_000B);
    drain();

    // Random traffic: loads while busy, data changes mid-transfer, aborts.
    for (int n = 0; n < 4000; n++) begin
      load_valid   = ($urandom_range(0, 3) == 0);
      load_pattern = 16'($urandom);
      load_len     = 4'($urandom);
      load_rep     = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      abort        = ($urandom_range(0, 59) == 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-sequence transmitter. It produces the single-bit stream C that the team's sequence-recognition FSMs consume.
- A parallel pattern, its length and a repeat count are loaded through a valid/ready handshake.
- The pattern is then shifted out MSB-first, one bit per clock, qualified by c_valid.
- It is the stimulus/transmit end of the serial-sequence interface, used both in-system and as a reusable source for recognizer testbenches.

Parameters:
- MAX_LEN, 16: width of the pattern register; maximum bits per repetition.
- LEN_W, 4: width of load_len; must equal clog2(MAX_LEN).
- REP_W, 4: width of load_rep.
- GAP_CYC, 2: idle cycles inserted between repetitions; 0 means back-to-back.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- load_valid, input, 1: load request.
- load_ready, output, 1: block can accept a load.
- load_pattern, input, MAX_LEN: bits to send; bit [load_len] is sent first, bit [0] last.
- load_len, input, LEN_W: bits per repetition minus 1 (0..MAX_LEN-1).
- load_rep, input, REP_W: repetitions minus 1.
- abort, input, 1: synchronous cancel.
- c_out, output, 1: serial data.
- c_valid, output, 1: c_out carries a pattern bit this cycle.
- busy, output, 1: transfer in progress (state != IDLE).
- done, output, 1: one-cycle completion pulse.

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset: state=IDLE; c_out=0, c_valid=0, busy=0, done=0, load_ready=1; internal counters and shift register cleared.
- Output timing:
  - c_out, c_valid, busy and done are registered.
  - load_ready is combinational from state only: 1 iff state==IDLE.
- States (without option): IDLE, SEND, GAP.
- IDLE:
  - On load_valid && load_ready at edge k: latch pattern, len, rep into holding registers.
  - Load shift register with pattern left-aligned, so bit [load_len] is at the MSB.
  - bit_cnt=len, rep_cnt=rep; go to SEND.
  - First bit appears with c_valid=1 in the cycle after edge k.
  - load_valid while not ready is ignored; no queuing.
- SEND:
  - Each cycle: c_valid=1, c_out=shift MSB; shift left, bit_cnt-1.
  - At bit_cnt==0 (last bit of this repetition):
    - rep_cnt!=0 and GAP_CYC>0: go to GAP.
    - rep_cnt!=0 and GAP_CYC==0: reload shift register from holding register, bit_cnt=len, rep_cnt-1, stay in SEND. No bubble.
    - rep_cnt==0: go to IDLE and assert done for exactly the next cycle. load_ready=1 in that same cycle.
- GAP:
  - c_valid=0, c_out=0 for exactly GAP_CYC cycles.
  - Then reload shift register, bit_cnt=len, rep_cnt-1, return to SEND.
- Totals per transfer:
  - c_valid-high cycles = (len+1)*(rep+1).
  - Cycles from accept to done = (len+1)*(rep+1) + rep*GAP_CYC + 1.
- Boundary cases:
  - len=0: single-bit repetitions.
  - len=MAX_LEN-1: full register is sent.
  - rep=max: 2^REP_W repetitions; rep_cnt never wraps.
- Data isolation: load_pattern/load_len/load_rep changes while busy have no effect on the transfer in progress.
- abort:
  - Sampled high in any non-IDLE state: next cycle state=IDLE, c_valid=0, c_out=0, done=0, busy=0.
  - abort in IDLE has no effect.
  - If abort and load_valid are both high in IDLE, the load is accepted; abort only cancels an active transfer.
- Reset mid-transfer: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: SEQ_PARITY_EN.
- When defined:
  - Adds state PAR, entered after the last data bit of every repetition.
  - PAR lasts one cycle: c_valid=1, c_out = XOR of the len+1 data bits of that repetition (even parity).
  - PAR then proceeds to GAP, SEND or IDLE with the same rules as SEND's last-bit exit.
  - c_valid-high cycles = (len+2)*(rep+1); done is delayed accordingly.
- When not defined: no PAR state, no parity logic; behaviour exactly as above.

Test Plan:
- Reset then single load: pattern=16'h000B, len=3, rep=0, no abort -> c_out sequence 1,0,1,1 with c_valid=1 for 4 consecutive cycles starting the cycle after accept; done pulses on cycle 5; load_ready=1 that same cycle.
- Repeat with gap: pattern=16'h0002, len=1, rep=2, GAP_CYC=2 -> c_valid pattern 11 00 11 00 11; c_out 1,0 per burst; done 1 cycle after the last bit; 11 cycles accept-to-done.
- Back-to-back repeats: GAP_CYC=0, pattern=16'h0001, len=0, rep=3 -> c_valid high 4 consecutive cycles, c_out=1,1,1,1; done once.
- Abort: len=15 full pattern 16'hA5A5, abort asserted after 5 bits -> c_valid=0 from the next cycle; no done pulse; load_ready=1; a fresh load is accepted immediately.
- Reset mid-operation: rst_n low during GAP -> all outputs 0 asynchronously, load_ready=1; a subsequent load behaves as in the first scenario.
- With SEQ_PARITY_EN: pattern=16'h0007, len=2, rep=1, GAP_CYC=0 -> c_out 1,1,1,1,1,1,1,1 (3 data + parity 1, twice); c_valid 8 cycles; done after.
